regfile_write_stage: RTL and testbench
======================================

// Module: regfile_write_stage
// PURPOSE
//  Storage and write side of the 32x64 ARM register file; sits directly upstream of the read-port
//  mux trees (16:1 / 4:1 slices), which consume rd_bus bit-slices.
//  Accepts write requests over a valid/ready handshake, stages them one cycle, then commits to the array.
//  Provides a sequential clear engine that zeroes all registers one per cycle.
//  X31 (XZR) is hardwired zero.
// PARAMETERS
//  NUM_REGS  32   number of architectural registers
//  DATA_W    64   register width in bits
//  ADDR_W    5    register index width, $clog2(NUM_REGS)
//  ZERO_REG  31   index hardwired to zero; writes to it are dropped
// PORTS
//  clk        in   1                one clock; all state on posedge
//  reset_n    in   1                asynchronous, active-low reset
//  wr_valid   in   1                write request valid
//  wr_ready   out  1                stage can accept a write this cycle
//  wr_addr    in   ADDR_W           destination register index
//  wr_data    in   DATA_W           write data
//  wr_commit  out  1                1-cycle pulse: staged write committed this edge
//  clr_req    in   1                start a full-array clear (level, sampled in IDLE)
//  clr_busy   out  1                clear engine running
//  rd_bus     out  NUM_REGS*DATA_W  flattened array; reg i = rd_bus[i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - array all 0; staging invalid; state IDLE; clr_cnt 0; wr_commit 0; clr_busy 0; rd_bus all 0.
//   - Reset mid-clear or mid-write aborts immediately; no partial state survives.
//  FSM IDLE/CLEAR:
//   - IDLE->CLEAR when clr_req=1.
//   - CLEAR holds NUM_REGS cycles; clr_cnt 0..NUM_REGS-1, zeroing reg[clr_cnt] each edge.
//   - CLEAR->IDLE on the edge writing index NUM_REGS-1; clr_cnt returns to 0.
//  Handshake:
//   - wr_ready = (state==IDLE) && !clr_req; combinational, no dependence on wr_valid.
//   - Accept on an edge with wr_valid&&wr_ready: addr/data captured into the staging register.
//   - wr_valid may drop without acceptance; data need only be stable while valid&&!ready.
//  Latency:
//   - Accepted at edge N -> written to array at edge N+1 -> visible on rd_bus after N+1.
//   - wr_commit is high for the cycle following edge N+1.
//   - Back-to-back accepts sustain 1 write/cycle; same-address back-to-back: later write wins.
//  Zero register:
//   - Writes to ZERO_REG are accepted and commit-pulsed; the array is unchanged.
//   - rd_bus slice ZERO_REG is constant 0.
//  Clear vs staged write:
//   - A staged write always commits, even if state has moved to CLEAR.
//   - Same edge and same index as a clear write: clear wins, result 0.
//  Indices >= NUM_REGS (only if NUM_REGS < 2**ADDR_W): accepted, dropped, commit-pulsed.
// CONFIGURATION
//  Macro: REGFILE_WRITE_BYPASS_EN
//  Defined:
//   - rd_bus overlays the staged data onto the staged index (when staging is valid and index != ZERO_REG).
//   - Readers therefore see a write 1 cycle earlier, right after accept edge N.
//   - Clear-zeroed indices are not overlaid while clr_busy=1.
//  Undefined:
//   - rd_bus is purely the array contents; latency as stated above.
// STRUCTURE
//  Package regfile_pkg:
//   - constants NUM_REGS, DATA_W, ADDR_W, ZERO_REG
//   - typedef reg_word_t (logic [DATA_W-1:0])
//   - enum rf_state_t {RF_IDLE, RF_CLEAR}
//  Sub-module decoder5to32:
//   - ADDR_W -> one-hot write-enable decode, gated by the commit enable.
//   - Instantiated once for the staged write and once for the clear index.
// TESTING
//  - Reset: reset_n=0 mid-run -> rd_bus==0, wr_ready=1 after release, clr_busy=0, wr_commit=0.
//  - Write X5=64'hDEAD_BEEF_0123_4567 accepted at edge N -> reg5 visible after N+1, wr_commit 1 cycle.
//    With bypass: visible after N.
//  - Write X31=64'hFFFF_FFFF_FFFF_FFFF -> wr_commit pulses; reg31 stays 0.
//  - Back-to-back writes X7=1 then X7=2 on consecutive edges -> reg7==2; two commit pulses.
//  - All regs = index value, then clr_req 1 cycle -> clr_busy high exactly 32 cycles, wr_ready=0 throughout;
//    after it drops, rd_bus==0.
//  - Write X0=64'hA5 accepted the edge clr_req rises -> X0 commits, then clear zeroes it.
//    Assert reset_n=0 at clear cycle 10 -> immediate IDLE, all 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, storage word type and clear-FSM states for the register-file write stage.
// Latency: none (declarations only); backpressure: none.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int ZERO_REG = 31;

  typedef logic [DATA_W-1:0] reg_word_t;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
endpackage

// File: rtl/decoder5to32.sv
// Register-index to one-hot write-enable decode, all-zero when disabled or index out of range.
// Latency: combinational; backpressure: none.
module decoder5to32
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
  end
endmodule

// File: rtl/regfile_write_stage.sv
// Register-file storage + write stage with sequential clear engine; REGFILE_WRITE_BYPASS_EN overlays staged data on rd_bus.
// Latency: accept edge N -> array write edge N+1; backpressure: wr_ready low while clearing or clr_req is asserted.
module regfile_write_stage
  import regfile_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  reg_word_t                  wr_data,
  output logic                       wr_commit,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic [NUM_REGS*DATA_W-1:0] rd_bus
);
  rf_state_t                          state_q, state_d;
  logic      [ADDR_W-1:0]             clr_cnt_q, clr_cnt_d;
  logic                               accept;
  logic                               stg_vld;
  logic      [ADDR_W-1:0]             stg_addr;
  reg_word_t                          stg_dat;
  logic      [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic      [NUM_REGS-1:0]           we_raw, we_wr, we_clr;

  assign wr_ready = (state_q == RF_IDLE) && !clr_req;
  assign clr_busy = (state_q == RF_CLEAR);
  assign accept   = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RF_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) state_d = RF_CLEAR;
      end
      RF_CLEAR: begin
        if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d   = RF_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_vld   <= 1'b0;
      stg_addr  <= '0;
      stg_dat   <= '0;
      wr_commit <= 1'b0;
    end else begin
      stg_vld   <= accept;
      wr_commit <= stg_vld;
      if (accept) begin
        stg_addr <= wr_addr;
        stg_dat  <= wr_data;
      end
    end
  end

  decoder5to32 u_dec_wr (
    .en     (stg_vld),
    .addr   (stg_addr),
    .onehot (we_raw)
  );

  decoder5to32 u_dec_clr (
    .en     (clr_busy),
    .addr   (clr_cnt_q),
    .onehot (we_clr)
  );

  // Zero register never takes a write; the commit pulse still fires for it.
  always_comb begin
    we_wr           = we_raw;
    we_wr[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_clr[i])     mem[i] <= '0;
        else if (we_wr[i]) mem[i] <= stg_dat;
      end
    end
  end

  always_comb begin
    rd_bus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      rd_bus[i*DATA_W +: DATA_W] = (we_wr[i] && !clr_busy) ? stg_dat : mem[i];
`else
      rd_bus[i*DATA_W +: DATA_W] = mem[i];
`endif
    end
    rd_bus[ZERO_REG*DATA_W +: DATA_W] = '0;
  end
endmodule

// File: tb/tb_regfile_write_stage.sv
// Self-checking bench for regfile_write_stage: directed scenarios plus randomized writes against a reference model.
module tb_regfile_write_stage;
  import regfile_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       wr_valid = 1'b0;
  logic                       wr_ready;
  logic [ADDR_W-1:0]          wr_addr = '0;
  reg_word_t                  wr_data = '0;
  logic                       wr_commit;
  logic                       clr_req = 1'b0;
  logic                       clr_busy;
  logic [NUM_REGS*DATA_W-1:0] rd_bus;

  int total = 0;
  int bad   = 0;

  reg_word_t model [NUM_REGS];

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_write_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_commit (wr_commit),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .rd_bus    (rd_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic reg_word_t rd(int i);
    return rd_bus[i*DATA_W +: DATA_W];
  endfunction

  function automatic int first_diff(logic [NUM_REGS*DATA_W-1:0] expv);
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_bus[i*DATA_W +: DATA_W] !== expv[i*DATA_W +: DATA_W]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    wr_addr = 5'd3; wr_data = 64'h1234_5678_9ABC_DEF0; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    total++;
    if (rd_bus !== '0) begin
      bad++; $display("FAIL reset_rd_bus first nonzero reg=%0d value=%h required 0", first_diff('0), rd(first_diff('0)));
    end
    total++;
    if (clr_busy !== 1'b0 || wr_commit !== 1'b0) begin
      bad++; $display("FAIL reset_outputs clr_busy=%b wr_commit=%b required 0 0", clr_busy, wr_commit);
    end
    tick();
    reset_n = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_wr_ready got=%b required 1", wr_ready);
    end
    clear_model();
  endtask

  task automatic test_write_x5();
    reg_word_t v = 64'hDEAD_BEEF_0123_4567;
    wr_addr = 5'd5; wr_data = v; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; wr_data = '0;
    total++;
    if (rd(5) !== (BYP ? v : 64'd0) || wr_commit !== 1'b0) begin
      bad++; $display("FAIL x5_after_accept reg5=%h commit=%b required %h 0", rd(5), wr_commit, BYP ? v : 64'd0);
    end
    tick();
    total++;
    if (rd(5) !== v || wr_commit !== 1'b1) begin
      bad++; $display("FAIL x5_after_commit reg5=%h commit=%b required %h 1", rd(5), wr_commit, v);
    end
    tick();
    total++;
    if (wr_commit !== 1'b0) begin
      bad++; $display("FAIL x5_commit_width commit=%b required 0", wr_commit);
    end
    model[5] = v;
  endtask

  task automatic test_zero_reg();
    wr_addr = 5'd31; wr_data = '1; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    total++;
    if (rd(31) !== 64'd0) begin
      bad++; $display("FAIL xzr_after_accept reg31=%h required 0", rd(31));
    end
    tick();
    total++;
    if (rd(31) !== 64'd0 || wr_commit !== 1'b1) begin
      bad++; $display("FAIL xzr_commit reg31=%h commit=%b required 0 1", rd(31), wr_commit);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    wr_addr = 5'd7; wr_data = 64'd1; wr_valid = 1'b1;
    tick();
    wr_data = 64'd2;
    total++;
    if (rd(7) !== (BYP ? 64'd1 : 64'd0)) begin
      bad++; $display("FAIL b2b_first_edge reg7=%h required %h", rd(7), BYP ? 64'd1 : 64'd0);
    end
    tick();
    wr_valid = 1'b0;
    total++;
    if (rd(7) !== (BYP ? 64'd2 : 64'd1) || wr_commit !== 1'b1) begin
      bad++; $display("FAIL b2b_second_edge reg7=%h commit=%b required %h 1", rd(7), wr_commit, BYP ? 64'd2 : 64'd1);
    end
    tick();
    total++;
    if (rd(7) !== 64'd2 || wr_commit !== 1'b1) begin
      bad++; $display("FAIL b2b_final reg7=%h commit=%b required 2 1", rd(7), wr_commit);
    end
    tick();
    total++;
    if (wr_commit !== 1'b0) begin
      bad++; $display("FAIL b2b_commit_count commit=%b required 0", wr_commit);
    end
    model[7] = 64'd2;
  endtask

  task automatic test_clear();
    logic [NUM_REGS*DATA_W-1:0] expv;
    int busy_cycles = 0;
    bit mid_checked = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_addr = ADDR_W'(i); wr_data = reg_word_t'(i); wr_valid = 1'b1;
      tick();
      if (i != ZERO_REG) model[i] = reg_word_t'(i);
    end
    wr_valid = 1'b0;
    repeat (2) tick();
    expv = '0;
    for (int i = 0; i < NUM_REGS; i++) expv[i*DATA_W +: DATA_W] = model[i];
    total++;
    if (rd_bus !== expv) begin
      bad++; $display("FAIL clear_fill reg=%0d got=%h", first_diff(expv), rd(first_diff(expv)));
    end
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 5'd9; wr_data = {$urandom, $urandom};
    #1;
    total++;
    if (wr_ready !== 1'b0) begin
      bad++; $display("FAIL clear_req_ready got=%b required 0", wr_ready);
    end
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 40 && clr_busy === 1'b1; k++) begin
      total++;
      if (wr_ready !== 1'b0 || wr_commit !== 1'b0) begin
        bad++; $display("FAIL clear_blocks_writes cycle=%0d wr_ready=%b wr_commit=%b required 0 0", k, wr_ready, wr_commit);
      end
      if (k == 16) begin
        mid_checked = 1'b1;
        total++;
        if (rd(15) !== 64'd0 || rd(16) !== 64'd16) begin
          bad++; $display("FAIL clear_progress reg15=%h reg16=%h required 0 10", rd(15), rd(16));
        end
      end
      busy_cycles++;
      tick();
    end
    wr_valid = 1'b0;
    total++;
    if (busy_cycles != NUM_REGS || !mid_checked) begin
      bad++; $display("FAIL clear_busy_cycles got=%0d required %0d", busy_cycles, NUM_REGS);
    end
    tick();
    total++;
    if (rd_bus !== '0) begin
      bad++; $display("FAIL clear_result reg=%0d value=%h required 0", first_diff('0), rd(first_diff('0)));
    end
    clear_model();
  endtask

  task automatic test_clear_with_write();
    for (int i = 1; i < ZERO_REG; i++) begin
      wr_addr = ADDR_W'(i); wr_data = {$urandom, $urandom}; wr_valid = 1'b1;
      model[i] = wr_data;
      tick();
    end
    wr_valid = 1'b0;
    repeat (2) tick();
    wr_addr = 5'd0; wr_data = 64'hA5; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; clr_req = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b0) begin
      bad++; $display("FAIL cw_ready got=%b required 0", wr_ready);
    end
    tick();
    clr_req = 1'b0;
    total++;
    if (rd(0) !== 64'hA5 || wr_commit !== 1'b1 || clr_busy !== 1'b1) begin
      bad++; $display("FAIL cw_commit reg0=%h commit=%b busy=%b required a5 1 1", rd(0), wr_commit, clr_busy);
    end
    tick();
    total++;
    if (rd(0) !== 64'd0) begin
      bad++; $display("FAIL cw_clear_reg0 reg0=%h required 0", rd(0));
    end
    repeat (9) tick();
    total++;
    if (clr_busy !== 1'b1 || rd(20) !== model[20]) begin
      bad++; $display("FAIL cw_mid_clear busy=%b reg20=%h required 1 %h", clr_busy, rd(20), model[20]);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (clr_busy !== 1'b0 || wr_commit !== 1'b0 || rd_bus !== '0) begin
      bad++; $display("FAIL cw_reset_abort busy=%b commit=%b first nonzero reg=%0d", clr_busy, wr_commit, first_diff('0));
    end
    tick();
    reset_n = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
      bad++; $display("FAIL cw_after_reset wr_ready=%b busy=%b required 1 0", wr_ready, clr_busy);
    end
    clear_model();
  endtask

  task automatic test_random();
    logic [NUM_REGS*DATA_W-1:0] expv;
    bit        pend_vld = 1'b0;
    int        pend_addr = 0;
    reg_word_t pend_dat = '0;
    bit        exp_commit = 1'b0;
    bit        drv_vld;
    int        drv_addr;
    reg_word_t drv_dat;
    for (int c = 0; c < 400; c++) begin
      expv = '0;
      for (int i = 0; i < NUM_REGS; i++) expv[i*DATA_W +: DATA_W] = model[i];
      if (BYP && pend_vld && pend_addr != ZERO_REG) expv[pend_addr*DATA_W +: DATA_W] = pend_dat;
      total++;
      if (rd_bus !== expv || wr_commit !== exp_commit || wr_ready !== 1'b1) begin
        bad++;
        $display("FAIL random cycle=%0d reg=%0d commit=%b required %b ready=%b", c, first_diff(expv), wr_commit, exp_commit, wr_ready);
      end
      drv_vld  = ($urandom_range(0, 9) < 7);
      drv_addr = int'($urandom_range(0, NUM_REGS - 1));
      drv_dat  = {$urandom, $urandom};
      wr_valid = drv_vld; wr_addr = ADDR_W'(drv_addr); wr_data = drv_dat;
      tick();
      exp_commit = pend_vld;
      if (pend_vld && pend_addr != ZERO_REG) model[pend_addr] = pend_dat;
      pend_vld = drv_vld; pend_addr = drv_addr; pend_dat = drv_dat;
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_x5();
    test_zero_reg();
    test_back_to_back();
    test_clear();
    test_clear_with_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
